// File: rtl/dpwm_duty_ctrl.sv
// Duty-cycle controller for the DPWM path.
// Sequences the external ramp counter, accepts inc/dec duty requests into a shadow register,
// commits the shadow to the active duty at each period boundary and drives the registered
// PWM compare output.
// Optional build macro: DPWM_SOFTSTART_EN -- active duty walks one STEP per commit toward the
// shadow value instead of jumping, and SYNC starts the active duty from zero.
module dpwm_duty_ctrl #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned STEP     = 50,
    parameter int unsigned MAX      = 1000,
    parameter int unsigned DUTY_RST = 500
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic             inc_req,
    input  logic             dec_req,
    input  logic [WIDTH-1:0] cuenta,
    output logic             cnt_rst,
    output logic             pwm_out,
    output logic [WIDTH-1:0] duty_shadow,
    output logic [WIDTH-1:0] duty_act,
    output logic             period_tick
);

    localparam logic [WIDTH-1:0] StepV = STEP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MaxV  = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RstV  = DUTY_RST[WIDTH-1:0];
    localparam logic [WIDTH:0]   StepX = STEP[WIDTH:0];
    localparam logic [WIDTH:0]   MaxX  = MAX[WIDTH:0];

    typedef enum logic [1:0] {StIdle, StSync, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] act_q, act_d;
    logic             pwm_q, pwm_d;
    logic             tick_q, tick_d;
    logic [WIDTH:0]   inc_sum;
    logic             commit;

    // Next state: IDLE waits for enable, SYNC lasts one cycle, RUN exits when enable drops.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StSync;
            StSync:  state_d = StRun;
            StRun:   if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Shadow duty update; the extra bit on the sum catches overflow past MAX.
    always_comb begin
        inc_sum  = {1'b0, shadow_q} + StepX;
        shadow_d = shadow_q;
        if (inc_req && !dec_req) begin
            shadow_d = (inc_sum > MaxX) ? MaxV : inc_sum[WIDTH-1:0];
        end else if (dec_req && !inc_req) begin
            shadow_d = (shadow_q < StepV) ? '0 : shadow_q - StepV;
        end
    end

    // Active duty: loaded in SYNC and at the period boundary, using the pre-request shadow.
    always_comb begin
        commit = (state_q == StRun) && (cuenta == MaxV);
        act_d  = act_q;
`ifdef DPWM_SOFTSTART_EN
        if (state_q == StSync) begin
            act_d = '0;
        end else if (commit) begin
            if (act_q < shadow_q) begin
                act_d = ((shadow_q - act_q) > StepV) ? act_q + StepV : shadow_q;
            end else if (act_q > shadow_q) begin
                act_d = ((act_q - shadow_q) > StepV) ? act_q - StepV : shadow_q;
            end
        end
`else
        if ((state_q == StSync) || commit) begin
            act_d = shadow_q;
        end
`endif
    end

    // PWM compare and period tick; gating with enable forces the output low on the exit cycle.
    always_comb begin
        pwm_d  = (state_q == StRun) && enable && (cuenta < act_q);
        tick_d = commit;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= StIdle;
            shadow_q <= RstV;
            act_q    <= RstV;
            pwm_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            act_q    <= act_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
        end
    end

    assign cnt_rst     = (state_q != StRun);
    assign pwm_out     = pwm_q;
    assign duty_shadow = shadow_q;
    assign duty_act    = act_q;
    assign period_tick = tick_q;

endmodule
